// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and constants for the data-memory arbiter slice.
//             - MEM_WORDS_DEFAULT : default number of data-memory words
//             - req_id_e          : requester identity (CPU / debug)
//             - mem_req_t         : one memory access (we, addr, wdata)
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam int MEM_WORDS_DEFAULT = 64;

    // Field widths of mem_req_t; the arbiter casts its port widths onto these.
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  we;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter with a per-requester mask.
//             Bit 0 is the CPU requester, bit 1 the debug requester.
//  Ports    : clk     - clock
//             rst     - synchronous active-high reset (pointer -> CPU)
//             i_req   - request vector
//             i_mask  - 1 = requester ineligible this cycle
//             o_gnt   - one-hot (or zero) grant, combinational
//             o_prio  - current priority owner
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt,
    output req_id_e    o_prio
);

    req_id_e    r_prio;
    logic [1:0] w_elig;
    logic [1:0] w_gnt;

    assign w_elig = i_req & ~i_mask;

    always_comb begin
        w_gnt = w_elig;
        if (w_elig == 2'b11) begin
            w_gnt = (r_prio == REQ_CPU) ? 2'b01 : 2'b10;
        end
    end

    // The pointer only moves on unmasked cycles: a masked-out requester has
    // not actually lost anything, so it keeps whatever priority it had.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= REQ_CPU;
        end else if ((|w_gnt) && (i_mask == 2'b00)) begin
            r_prio <= w_gnt[0] ? REQ_DBG : REQ_CPU;
        end
    end

    assign o_gnt  = w_gnt;
    assign o_prio = r_prio;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the single-port data memory between the CPU load/store
//             port and the debug/loader port. Grants are combinational,
//             responses come one cycle after the grant. Misaligned or
//             out-of-range accesses are granted but never touch memory and
//             answer with err=1.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             cpu_req/we/addr/wdata      - CPU request group
//             cpu_gnt/rvalid/rdata/err   - CPU response group
//             dbg_*                      - same for the debug port
//             dbg_lock                   - blocks all CPU grants while high
//             mem_we/addr/wdata, mem_rdata - memory side (1-cycle read)
//             err_cnt                    - saturating rejected-access count
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_gnt,
    output logic                         cpu_rvalid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_err,

    input  logic                         dbg_req,
    input  logic                         dbg_we,
    input  logic [ADDR_W-1:0]            dbg_addr,
    input  logic [DATA_W-1:0]            dbg_wdata,
    output logic                         dbg_gnt,
    output logic                         dbg_rvalid,
    output logic [DATA_W-1:0]            dbg_rdata,
    output logic                         dbg_err,

    input  logic                         dbg_lock,

    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,

    output logic [7:0]                   err_cnt
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    // ------------------------------------------------------------------
    // Legality: word aligned and word index inside the memory.
    // ------------------------------------------------------------------
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_W'(MEM_WORDS));
    endfunction

    logic     w_cpu_legal;
    logic     w_dbg_legal;
    logic     w_win_legal;
    logic     w_any_gnt;
    logic     w_err_gnt;
    logic     w_unused;
    logic [1:0] w_gnt;
    req_id_e  w_prio;
    mem_req_t w_cpu_req;
    mem_req_t w_dbg_req;
    mem_req_t w_win;

    logic       r_cpu_pend_rd;
    logic       r_cpu_pend_err;
    logic       r_dbg_pend_rd;
    logic       r_dbg_pend_err;
    logic [7:0] r_err_cnt;

    assign w_cpu_legal = addr_legal(cpu_addr);
    assign w_dbg_legal = addr_legal(dbg_addr);

    assign w_cpu_req = '{we: cpu_we, addr: REQ_ADDR_W'(cpu_addr), wdata: REQ_DATA_W'(cpu_wdata)};
    assign w_dbg_req = '{we: dbg_we, addr: REQ_ADDR_W'(dbg_addr), wdata: REQ_DATA_W'(dbg_wdata)};

    // ------------------------------------------------------------------
    // Arbitration. Requests are gated by reset so no grant (and hence no
    // memory write) can escape during the reset cycle.
    // ------------------------------------------------------------------
    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (reset),
        .i_req  ({dbg_req, cpu_req} & {2{~reset}}),
        .i_mask ({1'b0, dbg_lock}),
        .o_gnt  (w_gnt),
        .o_prio (w_prio)
    );

    assign cpu_gnt   = w_gnt[0];
    assign dbg_gnt   = w_gnt[1];
    assign w_any_gnt = |w_gnt;

    // With no grant the CPU fields are presented, keeping the memory
    // address/data deterministic on idle cycles.
    always_comb begin
        w_win       = w_cpu_req;
        w_win_legal = w_cpu_legal;
        if (w_gnt[1]) begin
            w_win       = w_dbg_req;
            w_win_legal = w_dbg_legal;
        end
    end

    assign mem_we    = w_any_gnt && w_win.we && w_win_legal;
    assign mem_addr  = w_win.addr[c_IDX_W+1:2];
    assign mem_wdata = DATA_W'(w_win.wdata);

    assign w_err_gnt = w_any_gnt && !w_win_legal;

    // ------------------------------------------------------------------
    // Response registers. A legal write produces no response; a rejected
    // access always answers, whatever its direction.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_pend_rd  <= 1'b0;
            r_cpu_pend_err <= 1'b0;
            r_dbg_pend_rd  <= 1'b0;
            r_dbg_pend_err <= 1'b0;
            r_err_cnt      <= 8'd0;
        end else begin
            r_cpu_pend_rd  <= cpu_gnt && w_cpu_legal && !cpu_we;
            r_cpu_pend_err <= cpu_gnt && !w_cpu_legal;
            r_dbg_pend_rd  <= dbg_gnt && w_dbg_legal && !dbg_we;
            r_dbg_pend_err <= dbg_gnt && !w_dbg_legal;
            if (w_err_gnt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Responses are suppressed while reset is high so a response that was
    // in flight when reset arrived is never seen by the requester.
    assign cpu_rvalid = !reset && (r_cpu_pend_rd || r_cpu_pend_err);
    assign cpu_err    = !reset && r_cpu_pend_err;
    assign cpu_rdata  = (!reset && r_cpu_pend_rd) ? mem_rdata : '0;

    assign dbg_rvalid = !reset && (r_dbg_pend_rd || r_dbg_pend_err);
    assign dbg_err    = !reset && r_dbg_pend_err;
    assign dbg_rdata  = (!reset && r_dbg_pend_rd) ? mem_rdata : '0;

    assign err_cnt = r_err_cnt;

    // Address bits outside the word index are only used by the legality
    // check; the priority pointer is observed only inside the arbiter.
    assign w_unused = ^{w_win.addr[REQ_ADDR_W-1:c_IDX_W+2], w_win.addr[1:0], w_prio};

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. A behavioural model
//             (word array, priority bit, expected responses) predicts every
//             output each cycle; directed scenarios are followed by a
//             randomized phase.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(c_WORDS)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .dbg_lock(dbg_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .err_cnt(err_cnt)
    );

    // Data memory stand-in: synchronous write, registered read.
    logic [31:0] ram [c_WORDS];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [c_WORDS];
    int          m_prio;            // 0 = CPU owns priority, 1 = debug
    int          m_cnt;
    bit          m_init;
    bit          m_cv, m_ce, m_dv, m_de;
    logic [31:0] m_cd, m_dd;
    bit          g_cpu, g_dbg;      // who won the last stepped cycle
    bit          cpu_drop, dbg_drop;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < c_WORDS);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 15)       return 32'($urandom_range(0, c_WORDS-1) * 4);
        else if (r == 15) return 32'(c_WORDS * 4);
        else if (r == 16) return 32'((c_WORDS-1) * 4);
        else if (r == 17) return 32'($urandom_range(0, c_WORDS-1) * 4 + $urandom_range(1, 3));
        else              return $urandom;
    endfunction

    // One clock cycle: check combinational and response outputs against the
    // model, advance the model at the edge, then release granted requests.
    task automatic step();
        bit          ec, ed, legal, we;
        int          win;
        logic [31:0] a, d;
        #1;
        ec  = cpu_req && !reset && !dbg_lock;
        ed  = dbg_req && !reset;
        win = -1;
        if (ec && ed)  win = m_prio;
        else if (ec)   win = 0;
        else if (ed)   win = 1;
        a     = (win == 1) ? dbg_addr  : cpu_addr;
        d     = (win == 1) ? dbg_wdata : cpu_wdata;
        we    = (win == 1) ? dbg_we    : cpu_we;
        legal = is_legal(a);

        check("cpu_gnt", 32'(cpu_gnt), 32'(win == 0));
        check("dbg_gnt", 32'(dbg_gnt), 32'(win == 1));
        check("mem_we",  32'(mem_we),  32'(win >= 0 && legal && we));
        if (win >= 0) begin
            check("mem_addr", 32'(mem_addr), (a / 4) % c_WORDS);
            if (legal && we) check("mem_wdata", mem_wdata, d);
        end
        if (m_init) begin
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(!reset && m_cv));
            check("cpu_err",    32'(cpu_err),    32'(!reset && m_ce));
            check("cpu_rdata",  cpu_rdata,       reset ? 32'd0 : m_cd);
            check("dbg_rvalid", 32'(dbg_rvalid), 32'(!reset && m_dv));
            check("dbg_err",    32'(dbg_err),    32'(!reset && m_de));
            check("dbg_rdata",  dbg_rdata,       reset ? 32'd0 : m_dd);
            check("err_cnt",    32'(err_cnt),    32'(m_cnt));
        end

        @(posedge clk);
        g_cpu = (win == 0);
        g_dbg = (win == 1);
        if (reset) begin
            m_prio = 0; m_cnt = 0; m_init = 1;
            m_cv = 0; m_ce = 0; m_dv = 0; m_de = 0; m_cd = 0; m_dd = 0;
        end else begin
            m_cv = g_cpu && !(legal && we);
            m_ce = g_cpu && !legal;
            m_cd = (g_cpu && legal && !we) ? ref_mem[a / 4] : 32'd0;
            m_dv = g_dbg && !(legal && we);
            m_de = g_dbg && !legal;
            m_dd = (g_dbg && legal && !we) ? ref_mem[a / 4] : 32'd0;
            if (win >= 0 && legal && we) ref_mem[a / 4] = d;
            if (win >= 0 && !legal && m_cnt < 255) m_cnt++;
            if (win >= 0 && !dbg_lock) m_prio = (win == 0) ? 1 : 0;
        end
        @(negedge clk);
        if (g_cpu && cpu_drop) cpu_req = 1'b0;
        if (g_dbg && dbg_drop) dbg_req = 1'b0;
    endtask

    // Present one access and step until it is granted (bounded).
    task automatic issue(input bit port, input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        if (!port) begin cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
        else       begin dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1; end
        do begin
            step();
            n++;
        end while (!(port ? g_dbg : g_cpu) && n < 8);
        if (!(port ? g_dbg : g_cpu)) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dbg_lock = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        m_init = 0; m_prio = 0; m_cnt = 0;
        m_cv = 0; m_ce = 0; m_dv = 0; m_de = 0; m_cd = 0; m_dd = 0;
        cpu_drop = 1; dbg_drop = 1;
        @(negedge clk);
        do_reset();

        // Preload every word through the debug port.
        for (int i = 0; i < c_WORDS; i++) issue(1'b1, 1'b1, 32'(i * 4), $urandom);

        // Solo CPU write then read of byte address 84 (word 21).
        issue(1'b0, 1'b1, 32'd84, 32'd7);
        issue(1'b0, 1'b0, 32'd84, 32'd0);
        step();
        check("solo_rdata", 32'(ref_mem[21]), 32'd7);

        // Continuous contention from reset: C, D, C, D ...
        do_reset();
        cpu_drop = 0; dbg_drop = 0;
        cpu_we = 0; cpu_addr = 32'd8; cpu_req = 1;
        dbg_we = 0; dbg_addr = 32'd12; dbg_req = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("contend_order", 32'(g_cpu), 32'((k % 2) == 0));
        end
        cpu_req = 0; dbg_req = 0; cpu_drop = 1; dbg_drop = 1;
        step();

        // Lock: CPU waits while debug performs five reads.
        dbg_lock = 1;
        cpu_we = 0; cpu_addr = 32'd16; cpu_req = 1;
        for (int k = 0; k < 5; k++) issue(1'b1, 1'b0, 32'($urandom_range(0, c_WORDS-1) * 4), 32'd0);
        dbg_lock = 0;
        step();
        check("lock_release", 32'(g_cpu), 32'd1);
        step();

        // Illegal accesses on both ports.
        do_reset();
        issue(1'b0, 1'b1, 32'h102, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 32'd256, 32'd0);
        step();
        check("illegal_cnt", 32'(err_cnt), 32'd2);

        // Reset in the cycle after a debug read grant.
        issue(1'b1, 1'b0, 32'd40, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Saturation of the error counter.
        cpu_drop = 0;
        cpu_we = 1; cpu_addr = 32'h400; cpu_wdata = 32'h1234_5678; cpu_req = 1;
        for (int k = 0; k < 300; k++) step();
        cpu_req = 0; cpu_drop = 1;
        step();
        check("sat_cnt", 32'(err_cnt), 32'd255);
        for (int i = 0; i < c_WORDS; i++) check("sat_mem", ram[i], ref_mem[i]);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            if (!cpu_req && $urandom_range(0, 9) < 6) begin
                cpu_we = 1'($urandom); cpu_addr = rand_addr(); cpu_wdata = $urandom; cpu_req = 1;
            end
            if (!dbg_req && $urandom_range(0, 9) < 6) begin
                dbg_we = 1'($urandom); dbg_addr = rand_addr(); dbg_wdata = $urandom; dbg_req = 1;
            end
            if (k % 23 == 0) dbg_lock = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
            reset = 1'b0;
        end
        dbg_lock = 0; cpu_req = 0; dbg_req = 0;
        step();
        step();
        for (int i = 0; i < c_WORDS; i++) check("final_mem", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the processor's single-port data memory. It shares the memory between the CPU load/store port and a debug/loader port, which is used by benches and bring-up to preload or inspect RAM words. The arbiter sits between the CPU and the data memory instance inside `top`. It gives each requester a request/grant/read-valid handshake, an exclusive debug lock, and alignment and range checking.

## Interface
Parameters:
- `DATA_W`, 32, data width of memory words and of both ports.
- `ADDR_W`, 32, byte-address width on both requester ports.
- `MEM_WORDS`, 64, number of memory words; the word index width is `$clog2(MEM_WORDS)`.

Ports:
- `clk` in 1 — system clock; all state changes on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `cpu_req` in 1 — CPU access request, level.
- `cpu_we` in 1 — 1 = write, 0 = read.
- `cpu_addr` in ADDR_W — byte address.
- `cpu_wdata` in DATA_W — write data.
- `cpu_gnt` out 1 — access accepted this cycle.
- `cpu_rvalid` out 1 — read data or error valid.
- `cpu_rdata` out DATA_W — read data.
- `cpu_err` out 1 — access rejected (misaligned or out of range).
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`, `dbg_err` — same meanings as the CPU group, for the debug port.
- `dbg_lock` in 1 — while high, the CPU is never granted.
- `mem_we` out 1 — memory write strobe.
- `mem_addr` out log2(MEM_WORDS) — word index.
- `mem_wdata` out DATA_W — memory write data.
- `mem_rdata` in DATA_W — memory read data, registered with 1-cycle latency.
- `err_cnt` out 8 — saturating count of rejected accesses.

## Operation
- **Requester rules:** a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. At most one grant is issued per cycle. Only one access is outstanding per port.
- **Arbitration:** round-robin with a 1-bit priority pointer `prio`, reset value CPU.
  - One requester eligible: it wins.
  - Both eligible: the `prio` owner wins.
  - After any grant, `prio` moves to the requester that did not win.
  - `dbg_lock=1` makes the CPU ineligible and leaves `prio` unchanged.
- **Grant:** `gnt` is combinational (Mealy) in the issue cycle.
  - `mem_addr = addr[log2(MEM_WORDS)+1:2]` of the winner.
  - `mem_we = winner.we` for a legal access; `mem_wdata` is the winner's `wdata`.
  - With no grant, `mem_we=0` and `mem_addr`/`mem_wdata` hold the CPU's fields (a don't-care, but deterministic).
- **Legality:** an access is illegal if `addr[1:0]!=0` or `addr>>2 >= MEM_WORDS`.
  - An illegal access is still granted, consuming the arbitration slot.
  - `mem_we` is forced to 0 for an illegal access.
- **Response:** registered; it appears in the cycle after the grant, on the granted port only.
  - Legal read: `rvalid=1`, `rdata=mem_rdata`, `err=0`.
  - Legal write: no response.
  - Illegal read or write: `rvalid=1`, `err=1`, `rdata=0`.
  - `err_cnt` increments by 1 per illegal grant and saturates at 255.
- **State:** `prio`, a response-pending register per port (`pend_rd`, `pend_err`), and `err_cnt`.

## Timing
- **Reset values:** after `reset`, on that edge:
  - all `gnt`, `rvalid` and `err` outputs are 0 (`gnt` is 0 while `reset`=1);
  - `rdata` outputs are 0, `mem_we` is 0, `err_cnt` is 0, `prio` is CPU, and pending responses are cleared.
- **Reset during an access:** a pending response is dropped and never delivered.
- **Latency:**
  - request to grant: 0 cycles when uncontested, at most 1 arbitration loss otherwise;
  - grant to `rvalid`: exactly 1 cycle;
  - write data is committed at the grant edge.
- **Back-to-back:** a port may be granted in the same cycle its previous `rvalid` is high, giving 1 access per cycle of throughput. With alternating winners under continuous contention, each port is granted every 2nd cycle.
- **Lock changes:** `dbg_lock` rising while a CPU response is pending does not cancel that response.
- **Simultaneous events:** for a simultaneous request and `dbg_lock` rise, the lock wins in the same cycle because the lock is sampled combinationally.
- **Boundary cases:**
  - address `(MEM_WORDS-1)*4` is legal; `MEM_WORDS*4` is illegal;
  - `err_cnt` at 255 plus an illegal grant stays at 255.

## Structure
- Shared package `dmem_pkg`:
  - `MEM_WORDS_DEFAULT`;
  - the requester enum `REQ_CPU=0`, `REQ_DBG=1`;
  - a `mem_req_t` struct (`we`, `addr`, `wdata`).
- One natural sub-module: `rr_arb2`, a 2-way round-robin arbiter with a mask input (for `dbg_lock`). It returns a one-hot grant and updates its pointer on grant.
- Legality check and response registers stay in `dmem_arbiter`.
- `top` instantiates `dmem_arbiter` between the CPU and data memory. Benches drive the `dbg_*` port to preload memory.

## Test plan
- **Solo CPU:** CPU writes 7 to address 84, then reads 84.
  - Required: write `gnt` in the same cycle and `mem_we=1`, `mem_addr=21`.
  - Required: the read returns `rvalid=1`, `rdata=7` exactly one cycle after its `gnt`.
- **Contention:** both ports request continuously from reset.
  - Required grants are C, D, C, D…; each port receives exactly 1 grant per 2 cycles.
- **Lock:** with `dbg_lock=1`, CPU requests for 5 cycles while debug performs 5 reads.
  - Required: `cpu_gnt=0` throughout.
  - Required: after lock drop, `cpu_gnt=1` in the next cycle.
- **Illegal accesses:** CPU writes address 0x102, then debug reads address 256 (`MEM_WORDS`=64).
  - Required: both are granted with `mem_we=0`.
  - Required: `err=1`, `rvalid=1`, `rdata=0` on each port in the next cycle, and `err_cnt=2`.
- **Reset mid-read:** assert `reset` in the cycle after a debug read grant.
  - Required: `dbg_rvalid` is never asserted for that read, and all outputs and `err_cnt` are 0.
- **Saturation:** issue 300 illegal CPU accesses.
  - Required: `err_cnt=255` and holding; memory contents are unchanged.
